// File: rtl/bnn_weight_loader.sv
`default_nettype none
// ============================================================================
// bnn_weight_loader : framed nibble-stream loader for the BNN weight/threshold
// register file. Optional macro BNN_LOADER_CHECKSUM_EN adds the XOR checksum
// nibble, the CHK state and the err flag.
// Revision: 1.0
// ============================================================================
module bnn_weight_loader #(
  parameter int NUM_NEURONS = 20,
  parameter int ADDR_W      = 5,
  parameter int WEIGHT_W    = 8,
  parameter int THR_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                load_en,
  input  logic [3:0]          nibble_in,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [WEIGHT_W-1:0] wr_weight,
  output logic [THR_W-1:0]    wr_thr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W_LO = 3'd1,
    W_HI = 3'd2,
    THR  = 3'd3,
    CHK  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [3:0]            lo_q, lo_d;
  logic [3:0]            hi_q, hi_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [WEIGHT_W-1:0]   wr_weight_q, wr_weight_d;
  logic [THR_W-1:0]      wr_thr_q, wr_thr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef BNN_LOADER_CHECKSUM_EN
  logic [3:0]            acc_q, acc_d;
  logic                  err_q, err_d;
`endif

  logic w_accept;
  assign w_accept = ena & load_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_weight_q <= '0;
      wr_thr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BNN_LOADER_CHECKSUM_EN
      acc_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_weight_q <= wr_weight_d;
      wr_thr_q    <= wr_thr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef BNN_LOADER_CHECKSUM_EN
      acc_q       <= acc_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_weight_d = wr_weight_q;
    wr_thr_d    = wr_thr_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef BNN_LOADER_CHECKSUM_EN
    acc_d       = acc_q;
    err_d       = err_q;
`endif

    if (w_accept) begin
      case (state_q)
        IDLE: begin
          // First nibble of a frame is always weight[3:0] of neuron 0.
          lo_d    = nibble_in;
          idx_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = W_HI;
`ifdef BNN_LOADER_CHECKSUM_EN
          acc_d   = nibble_in;
          err_d   = 1'b0;
`endif
        end
        W_LO: begin
          lo_d    = nibble_in;
          state_d = W_HI;
`ifdef BNN_LOADER_CHECKSUM_EN
          acc_d   = acc_q ^ nibble_in;
`endif
        end
        W_HI: begin
          hi_d    = nibble_in;
          state_d = THR;
`ifdef BNN_LOADER_CHECKSUM_EN
          acc_d   = acc_q ^ nibble_in;
`endif
        end
        THR: begin
          wr_en_d     = 1'b1;
          wr_addr_d   = idx_q;
          wr_weight_d = {hi_q, lo_q};
          wr_thr_d    = nibble_in;
`ifdef BNN_LOADER_CHECKSUM_EN
          acc_d       = acc_q ^ nibble_in;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef BNN_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
`endif
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = W_LO;
          end
        end
`ifdef BNN_LOADER_CHECKSUM_EN
        CHK: begin
          if (nibble_in == acc_q) begin
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_weight = wr_weight_q;
  assign wr_thr    = wr_thr_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef BNN_LOADER_CHECKSUM_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/bnn_weight_loader.md
Name: bnn_weight_loader

Overview:
Upstream configuration stage for the 8-8-4 BNN core. It accepts a framed nibble stream on the bidir pins and assembles one 8-bit weight and one 4-bit threshold per neuron. It then issues single-cycle write strobes into the neuron weight/threshold register file, replacing the core's unframed two-nibble loader. Frame integrity is checked with an XOR checksum, and completion or error is reported.

Parameters:
NUM_NEURONS, 20, neurons per frame (records before checksum)
ADDR_W, 5, width of wr_addr; must satisfy 2**ADDR_W >= NUM_NEURONS
WEIGHT_W, 8, weight bits per neuron; fixed at 2 nibbles
THR_W, 4, threshold bits per neuron; fixed at 1 nibble

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
ena  input  1  design enable; low = full stall, no state change
load_en  input  1  nibble valid; sampled with nibble_in when ena=1
nibble_in  input  4  stream data (uio_in[7:4] at top level)
wr_en  output  1  one-cycle write strobe to weight/threshold file
wr_addr  output  ADDR_W  neuron index for the write
wr_weight  output  WEIGHT_W  {hi nibble, lo nibble}
wr_thr  output  THR_W  threshold nibble
busy  output  1  high while a frame is in progress
done  output  1  frame completed, checksum good; sticky
err  output  1  frame completed, checksum bad; sticky

Behaviour:
- Reset is synchronous, active-high. On the reset edge: state=IDLE, record index=0, checksum accumulator=0, nibble buffers=0. Outputs: wr_en=0, wr_addr=0, wr_weight=0, wr_thr=0, busy=0, done=0, err=0.
- A nibble is accepted on a cycle where ena=1 and load_en=1. On any other cycle the FSM holds state, index and accumulator. This stalls the frame; it does not abort it.
- FSM states: IDLE, W_LO, W_HI, THR, CHK.
  - IDLE: an accepted nibble is weight[3:0] of neuron 0. Latch it, acc<=nibble, index<=0, clear done/err, busy<=1, go W_HI.
  - W_LO: latch weight[3:0], acc^=nibble, go W_HI.
  - W_HI: latch weight[7:4], acc^=nibble, go THR.
  - THR: latch threshold, acc^=nibble, schedule the write. If index==NUM_NEURONS-1, go CHK. Otherwise index++ and go W_LO.
  - CHK: compare nibble against acc. Equal sets done<=1; unequal sets err<=1. Then busy<=0 and go IDLE.
- The IDLE entry path is the only place the frame-first nibble is handled; W_LO is used for neurons 1..NUM_NEURONS-1.
- Write timing: wr_en=1 for exactly one cycle, on the cycle after the THR nibble is accepted. wr_addr, wr_weight and wr_thr are registered and valid in that same cycle, and hold their values until the next write.
- Writes are not gated by the checksum. A bad frame still updates the register file; err flags it to the host.
- done and err are mutually exclusive. Each stays set until the next frame's first nibble is accepted, or until reset.
- Continuous load_en after CHK starts a new frame on the next accepted nibble.
- Reset mid-frame: the FSM returns to IDLE and no further writes occur. A wr_en already scheduled for the reset cycle is suppressed (reset has priority).
- ena=0 with load_en=1: nothing is accepted. A pending wr_en still fires; the write pipeline is not stalled by ena.
- Index arithmetic is ADDR_W bits wide and never exceeds NUM_NEURONS-1; there is no wrap.

Optional Feature:
Macro: BNN_LOADER_CHECKSUM_EN
- Defined: the CHK state and accumulator exist, and behaviour is as above.
- Undefined:
  - THR of the last neuron goes directly to IDLE and sets done<=1 and busy<=0 in that same transition.
  - err is tied to 0.
  - The accumulator logic is removed.

Test Plan:
- Reset then idle: hold reset 2 cycles with load_en=1 -> all outputs 0; no wr_en for 5 cycles after release with load_en=0.
- NUM_NEURONS=2, stream B,7,4,3,8,4,7 back-to-back. Expected response:
  - wr_en at cycles 4 and 7, with (addr0, 0x7B, 0x4) and (addr1, 0x83, 0x4).
  - done=1 after the 7th nibble, err=0, busy=0.
- Same stream with checksum 6 -> both writes still occur; err=1, done=0.
- Same stream with load_en dropped for 3 cycles after the 2nd nibble, and ena dropped for 2 cycles after the 5th -> identical writes and done=1, only delayed accordingly.
- Default NUM_NEURONS=20, reset asserted after the 10th nibble, then a full valid 61-nibble frame -> exactly 3 writes before the reset (addr 0..2); after it, 20 writes addr 0..19 and done=1.
- BNN_LOADER_CHECKSUM_EN undefined, NUM_NEURONS=2, stream B,7,4,3,8,4 -> done=1 directly after the 6th nibble; a 7th nibble starts a new frame (busy=1, done cleared).
